// File: rtl/sent_rx_pkg.sv
// Shared types and constants for the SENT fast-channel receiver.
// Holds the FSM state enum, interval classes, timing constants and the J2716 CRC table.
package sent_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_TAIL
    } rx_state_t;

    typedef enum logic [1:0] {
        CLS_BAD,
        CLS_SYNC,
        CLS_NIB,
        CLS_PAUSE
    } interval_cls_t;

    localparam int SYNC_TICKS = 56;
    localparam int NIB_MIN    = 12;
    localparam int NIB_MAX    = 27;
    localparam int PAUSE_MAX  = 768;

    localparam logic [3:0] CRC_SEED = 4'b0101;

    // Remainder of idx * x^4 modulo x^4+x^3+x^2+1.
    function automatic logic [3:0] crc4_table(input logic [3:0] idx);
        logic [3:0] t;
        case (idx)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sent_rx_crc4.sv
// One nibble step of the SENT 4-bit CRC; feeding nib=0 gives the final augmentation step.
module sent_rx_crc4 import sent_rx_pkg::*; (
    input  logic [3:0] crc_in,
    input  logic [3:0] nib,
    output logic [3:0] crc_out
);

    assign crc_out = nib ^ crc4_table(crc_in);

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT fast-channel receiver: measures falling-edge intervals, decodes status/data/CRC nibbles.
// Define SENT_RX_PAUSE_EN to accept one pause pulse between frames.
module sent_rx_decoder import sent_rx_pkg::*; #(
    parameter int CLK_PER_TICK = 8,
    parameter int SYNC_TOL     = 1,
    parameter int MAX_TICKS    = 1023
) (
    input  logic        clk_rx,
    input  logic        reset_rx,
    input  logic        enable,
    input  logic        data_pulse,
    output logic        frame_valid,
    output logic [3:0]  status,
    output logic [23:0] data_nibbles,
    output logic [3:0]  crc_rx,
    output logic        crc_err,
    output logic        frame_err
);

    localparam int PW = $clog2(CLK_PER_TICK);
    localparam int TW = $clog2(MAX_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_PER_TICK / 2);
    localparam logic [TW-1:0] TICK_SAT   = TW'(MAX_TICKS);
    localparam logic [TW-1:0] SYNC_LO    = TW'(SYNC_TICKS - SYNC_TOL);
    localparam logic [TW-1:0] SYNC_HI    = TW'(SYNC_TICKS + SYNC_TOL);
    localparam logic [TW-1:0] NIB_LO     = TW'(NIB_MIN);
    localparam logic [TW-1:0] NIB_HI     = TW'(NIB_MAX);
    localparam logic [TW-1:0] PAUSE_HI   = TW'(PAUSE_MAX);

    logic [2:0]    sync_reg;
    logic          fe;
    logic [PW-1:0] presc_reg;
    logic [TW-1:0] tick_cnt_reg;
    interval_cls_t cls;
    logic [3:0]    nib_val;
    logic          timeout;

    rx_state_t   state_reg, state_next;
    logic [2:0]  nib_idx_reg, nib_idx_next;
    logic [3:0]  crc_reg, crc_next, crc_step, crc_final;
    logic [3:0]  status_work_reg, status_work_next;
    logic [23:0] data_work_reg, data_work_next;
    logic        ev_frame, ev_abort;
`ifdef SENT_RX_PAUSE_EN
    logic        pause_seen_reg, pause_seen_next;
`endif

    logic        frame_valid_reg, frame_valid_next;
    logic        frame_err_reg, frame_err_next;
    logic        crc_err_reg, crc_err_next;
    logic [3:0]  status_reg, status_next;
    logic [3:0]  crc_rx_reg, crc_rx_next;
    logic [23:0] data_reg, data_next;

    // Bits [1:0] synchronise the line, bit [2] is the edge register.
    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) sync_reg <= 3'b111;
        else           sync_reg <= {sync_reg[1:0], data_pulse};
    end

    assign fe = sync_reg[2] & ~sync_reg[1];

    // Reloading the prescaler at half a tick rounds each interval to the nearest tick.
    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
        end else if (fe) begin
            presc_reg    <= PRESC_HALF;
            tick_cnt_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
            if (tick_cnt_reg != TICK_SAT) tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    always_comb begin
        cls = CLS_BAD;
        if (tick_cnt_reg >= SYNC_LO && tick_cnt_reg <= SYNC_HI)      cls = CLS_SYNC;
        else if (tick_cnt_reg >= NIB_LO && tick_cnt_reg <= NIB_HI)   cls = CLS_NIB;
        else if (tick_cnt_reg >= NIB_LO && tick_cnt_reg <= PAUSE_HI) cls = CLS_PAUSE;
    end

    assign nib_val = 4'(tick_cnt_reg - NIB_LO);
    assign timeout = (tick_cnt_reg == TICK_SAT) && (state_reg != ST_WAIT_SYNC);

    sent_rx_crc4 u_crc_step (
        .crc_in  (crc_reg),
        .nib     (nib_val),
        .crc_out (crc_step)
    );

    sent_rx_crc4 u_crc_final (
        .crc_in  (crc_reg),
        .nib     (4'd0),
        .crc_out (crc_final)
    );

    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            state_reg       <= ST_WAIT_SYNC;
            nib_idx_reg     <= '0;
            crc_reg         <= '0;
            status_work_reg <= '0;
            data_work_reg   <= '0;
`ifdef SENT_RX_PAUSE_EN
            pause_seen_reg  <= 1'b0;
`endif
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            crc_err_reg     <= 1'b0;
            status_reg      <= '0;
            crc_rx_reg      <= '0;
            data_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            nib_idx_reg     <= nib_idx_next;
            crc_reg         <= crc_next;
            status_work_reg <= status_work_next;
            data_work_reg   <= data_work_next;
`ifdef SENT_RX_PAUSE_EN
            pause_seen_reg  <= pause_seen_next;
`endif
            frame_valid_reg <= frame_valid_next;
            frame_err_reg   <= frame_err_next;
            crc_err_reg     <= crc_err_next;
            status_reg      <= status_next;
            crc_rx_reg      <= crc_rx_next;
            data_reg        <= data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        nib_idx_next     = nib_idx_reg;
        crc_next         = crc_reg;
        status_work_next = status_work_reg;
        data_work_next   = data_work_reg;
`ifdef SENT_RX_PAUSE_EN
        pause_seen_next  = pause_seen_reg;
`endif
        ev_frame         = 1'b0;
        ev_abort         = 1'b0;
        if (!enable) begin
            state_next = ST_WAIT_SYNC;
        end else if (fe) begin
            case (state_reg)
                ST_WAIT_SYNC: if (cls == CLS_SYNC) state_next = ST_STATUS;
                ST_STATUS, ST_DATA, ST_CRC: begin
                    if (cls == CLS_SYNC) begin
                        ev_abort   = 1'b1;
                        state_next = ST_STATUS;
                        crc_next   = CRC_SEED;
                    end else if (cls != CLS_NIB) begin
                        ev_abort   = 1'b1;
                        state_next = ST_WAIT_SYNC;
                    end else if (state_reg == ST_STATUS) begin
                        status_work_next = nib_val;
                        crc_next         = CRC_SEED;
                        nib_idx_next     = '0;
                        state_next       = ST_DATA;
                    end else if (state_reg == ST_DATA) begin
                        data_work_next = {data_work_reg[19:0], nib_val};
                        crc_next       = crc_step;
                        if (nib_idx_reg == 3'd5) state_next = ST_CRC;
                        else                     nib_idx_next = nib_idx_reg + 3'd1;
                    end else begin
                        ev_frame   = 1'b1;
                        state_next = ST_TAIL;
`ifdef SENT_RX_PAUSE_EN
                        pause_seen_next = 1'b0;
`endif
                    end
                end
                ST_TAIL: begin
                    if (cls == CLS_SYNC) state_next = ST_STATUS;
`ifdef SENT_RX_PAUSE_EN
                    else if (!pause_seen_reg && (cls == CLS_NIB || cls == CLS_PAUSE))
                        pause_seen_next = 1'b1;
`endif
                    else begin
                        ev_abort   = 1'b1;
                        state_next = ST_WAIT_SYNC;
                    end
                end
                default: state_next = ST_WAIT_SYNC;
            endcase
        end else if (timeout) begin
            ev_abort   = 1'b1;
            state_next = ST_WAIT_SYNC;
        end
    end

    // Frame outputs only move on a completed frame; aborts leave them untouched.
    always_comb begin
        frame_valid_next = ev_frame;
        frame_err_next   = ev_abort;
        status_next      = status_reg;
        data_next        = data_reg;
        crc_rx_next      = crc_rx_reg;
        crc_err_next     = crc_err_reg;
        if (ev_frame) begin
            status_next  = status_work_reg;
            data_next    = data_work_reg;
            crc_rx_next  = nib_val;
            crc_err_next = (crc_final != nib_val);
        end
    end

    assign frame_valid  = frame_valid_reg;
    assign frame_err    = frame_err_reg;
    assign status       = status_reg;
    assign data_nibbles = data_reg;
    assign crc_rx       = crc_rx_reg;
    assign crc_err      = crc_err_reg;

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Bench for sent_rx_decoder: drives interval sequences on the SENT line and compares
// the observed frame/abort events against an interval-level reference model.
module tb_sent_rx_decoder;

    localparam int CPT      = 8;
    localparam int LOW_CLKS = 4 * CPT;
    localparam logic [33:0] ERR_EV = {1'b1, 33'd0};
`ifdef SENT_RX_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic        clk_rx = 1'b0;
    logic        reset_rx = 1'b0;
    logic        enable = 1'b1;
    logic        data_pulse = 1'b1;
    logic        frame_valid, crc_err, frame_err;
    logic [3:0]  status, crc_rx;
    logic [23:0] data_nibbles;

    int total = 0;
    int bad = 0;
    int          ivq[$];
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];

    sent_rx_decoder #(
        .CLK_PER_TICK (CPT),
        .SYNC_TOL     (1),
        .MAX_TICKS    (1023)
    ) dut (
        .clk_rx       (clk_rx),
        .reset_rx     (reset_rx),
        .enable       (enable),
        .data_pulse   (data_pulse),
        .frame_valid  (frame_valid),
        .status       (status),
        .data_nibbles (data_nibbles),
        .crc_rx       (crc_rx),
        .crc_err      (crc_err),
        .frame_err    (frame_err)
    );

    always #5 clk_rx = ~clk_rx;

    always @(negedge clk_rx) begin
        if (frame_valid) begin
            obs_q.push_back({1'b0, status, data_nibbles, crc_rx, crc_err});
            $display("[%0t] frame status=%h data=%h crc=%h crc_err=%b", $time, status, data_nibbles, crc_rx, crc_err);
        end
        if (frame_err) begin
            obs_q.push_back(ERR_EV);
            $display("[%0t] frame_err", $time);
        end
    end

    // CRC as polynomial remainder of (seed, data, zero nibble) by x^4+x^3+x^2+1.
    function automatic logic [3:0] ref_crc(input logic [23:0] d);
        logic [31:0] m;
        m = {4'h5, d, 4'h0};
        for (int i = 31; i >= 4; i--)
            if (m[i]) m = m ^ (32'h1D << (i - 4));
        return m[3:0];
    endfunction

    function automatic void add_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] c);
        ivq.push_back(56);
        ivq.push_back(int'(st) + 12);
        for (int k = 5; k >= 0; k--) ivq.push_back(int'(d[4*k +: 4]) + 12);
        ivq.push_back(int'(c) + 12);
    endfunction

    // Walks the interval list frame by frame; pos -1 = hunting sync, 0..7 = nibble slot, 8 = after CRC.
    function automatic void model_run();
        int pos;
        bit ps, is_sync, is_nib, is_pause;
        logic [3:0]  st, c;
        logic [23:0] d;
        int t;
        pos = -1; ps = 0; st = '0; d = '0;
        exp_q.delete();
        foreach (ivq[i]) begin
            t = ivq[i];
            is_sync  = (t >= 55 && t <= 57);
            is_nib   = (t >= 12 && t <= 27);
            is_pause = !is_nib && (t >= 12 && t <= 768);
            if (t >= 1023) begin
                if (pos != -1) exp_q.push_back(ERR_EV);
                pos = -1;
            end else if (pos == -1) begin
                if (is_sync) pos = 0;
            end else if (pos <= 7) begin
                if (is_sync) begin
                    exp_q.push_back(ERR_EV); pos = 0;
                end else if (!is_nib) begin
                    exp_q.push_back(ERR_EV); pos = -1;
                end else if (pos == 0) begin
                    st = 4'(t - 12); pos = 1;
                end else if (pos <= 6) begin
                    d = {d[19:0], 4'(t - 12)}; pos++;
                end else begin
                    c = 4'(t - 12);
                    exp_q.push_back({1'b0, st, d, c, (c != ref_crc(d))});
                    pos = 8; ps = 0;
                end
            end else begin
                if (is_sync) pos = 0;
                else if (PAUSE_EN && !ps && (is_nib || is_pause)) ps = 1;
                else begin exp_q.push_back(ERR_EV); pos = -1; end
            end
        end
    endfunction

    // Start edge, then one falling edge at the end of every interval in ivq.
    task automatic send_ivs(input bit jit, input bit release_en);
        int n;
        obs_q.delete();
        @(negedge clk_rx); data_pulse = 1'b0;
        foreach (ivq[i]) begin
            n = ivq[i] * CPT;
            if (jit) n = n + int'($urandom_range(6)) - 3;
            repeat (LOW_CLKS) @(negedge clk_rx);
            data_pulse = 1'b1;
            repeat (n - LOW_CLKS) @(negedge clk_rx);
            data_pulse = 1'b0;
        end
        repeat (LOW_CLKS) @(negedge clk_rx);
        data_pulse = 1'b1;
        repeat (6) @(negedge clk_rx);
        if (release_en) begin
            enable = 1'b0;
            repeat (3) @(negedge clk_rx);
            enable = 1'b1;
            repeat (2) @(negedge clk_rx);
        end
    endtask

    task automatic test_reset();
        reset_rx = 1'b0; enable = 1'b1; data_pulse = 1'b1;
        repeat (4) @(negedge clk_rx);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
        total++; if (status !== 4'h0) begin bad++; $display("FAIL reset_status got=%h want=0", status); end
        total++; if (data_nibbles !== 24'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_nibbles); end
        total++; if (crc_rx !== 4'h0) begin bad++; $display("FAIL reset_crc got=%h want=0", crc_rx); end
        total++; if (crc_err !== 1'b0) begin bad++; $display("FAIL reset_crc_err got=%b want=0", crc_err); end
        reset_rx = 1'b1;
        repeat (4) @(negedge clk_rx);
    endtask

    task automatic test_crc();
        ivq.delete();
        add_frame(4'h0, 24'h123456, 4'h2);
        add_frame(4'h0, 24'h123456, 4'h3);
        model_run();
        send_ivs(1'b0, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL crc_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL crc_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (data_nibbles !== 24'h123456) begin bad++; $display("FAIL crc_data got=%h want=123456", data_nibbles); end
        total++; if (crc_rx !== 4'h3) begin bad++; $display("FAIL crc_rx got=%h want=3", crc_rx); end
        total++; if (crc_err !== 1'b1) begin bad++; $display("FAIL crc_err_flag got=%b want=1", crc_err); end
    endtask

    task automatic test_async_reset();
        ivq = {56, 19, 13, 14};
        send_ivs(1'b0, 1'b0);
        @(posedge clk_rx); #2; reset_rx = 1'b0; #1;
        total++; if (status !== 4'h0) begin bad++; $display("FAIL areset_status got=%h want=0", status); end
        total++; if (data_nibbles !== 24'h0) begin bad++; $display("FAIL areset_data got=%h want=0", data_nibbles); end
        total++; if (crc_rx !== 4'h0) begin bad++; $display("FAIL areset_crc got=%h want=0", crc_rx); end
        total++; if (crc_err !== 1'b0) begin bad++; $display("FAIL areset_crc_err got=%b want=0", crc_err); end
        @(negedge clk_rx); reset_rx = 1'b1;
        repeat (2) @(negedge clk_rx);
        ivq.delete();
        add_frame(4'hA, 24'h0F1E2D, ref_crc(24'h0F1E2D));
        model_run();
        send_ivs(1'b0, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL areset_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL areset_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_jitter();
        ivq.delete();
        add_frame(4'h9, 24'h000000, 4'h5);
        model_run();
        send_ivs(1'b1, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL jitter_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL jitter_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (crc_err !== 1'b0) begin bad++; $display("FAIL jitter_crc_err got=%b want=0", crc_err); end
        total++; if (status !== 4'h9) begin bad++; $display("FAIL jitter_status got=%h want=9", status); end
    endtask

    task automatic test_abort();
        // bad interval after the third data nibble, then a clean frame
        ivq = {56, 12, 13, 14, 15, 30};
        add_frame(4'h5, 24'hABCDEF, ref_crc(24'hABCDEF));
        // resync mid-frame: the nibbles after the second sync form a new frame
        ivq.push_back(56); ivq.push_back(13); ivq.push_back(20);
        add_frame(4'h3, 24'h654321, ref_crc(24'h654321));
        model_run();
        send_ivs(1'b1, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        ivq = {56, 15, 17, 19, 1100};
        model_run();
        send_ivs(1'b0, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL timeout_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL timeout_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            ivq.delete();
            add_frame(4'h1, 24'h13579B, ref_crc(24'h13579B));
            if (pass == 1) ivq.push_back(200);
            add_frame(4'h2, 24'h2468AC, ref_crc(24'h2468AC));
            model_run();
            send_ivs(1'b0, 1'b1);
            total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b%0d_count got=%0d want=%0d", pass, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b%0d_ev%0d got=%h want=%h", pass, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_enable();
        ivq.delete();
        add_frame(4'h7, 24'h777777, ref_crc(24'h777777));
        enable = 1'b0;
        send_ivs(1'b0, 1'b1);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL enable_events got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_random();
        logic [23:0] d;
        logic [3:0]  c;
        for (int round = 0; round < 2; round++) begin
            ivq.delete();
            for (int f = 0; f < 5; f++) begin
                d = 24'($urandom);
                c = ref_crc(d);
                if ($urandom_range(3) == 0) c = c ^ 4'(1 + $urandom_range(14));
                add_frame(4'($urandom), d, c);
                if ($urandom_range(2) == 0) ivq.push_back(int'($urandom_range(60, 300)));
            end
            model_run();
            send_ivs(1'b1, 1'b1);
            total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", round, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_ev%0d got=%h want=%h", round, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc();
        test_async_reset();
        test_jitter();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
